// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesting pipeline units and the shared-ALU arbiter.
// Per-requester operand and opcode fields are packed as [i*WIDTH +: WIDTH].
interface alu_share_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32,
    parameter int OP_W  = 4
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*XLEN-1:0] req_src_a;
    logic [N_REQ*XLEN-1:0] req_src_b;
    logic [N_REQ*OP_W-1:0] req_op;
    logic [N_REQ-1:0]      rsp_valid;
    logic [N_REQ-1:0]      rsp_ready;
    logic [XLEN-1:0]       rsp_result;

    modport master (
        output req_valid, req_src_a, req_src_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_src_a, req_src_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between N_REQ requesters:
// accept -> drive ALU from operand registers -> hold result on a valid/ready response.
module alu_share_arbiter #(
    parameter int N_REQ = 2,
    parameter int XLEN  = 32,
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus,
    output logic [XLEN-1:0]    alu_src_a,
    output logic [XLEN-1:0]    alu_src_b,
    output logic [OP_W-1:0]    alu_op,
    input  logic [XLEN-1:0]    alu_result,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [OP_W-1:0] ALU_ADD = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       owner_p0;
    logic signed [XLEN-1:0] src_a_p0;
    logic signed [XLEN-1:0] src_b_p0;
    logic [OP_W-1:0]        op_p0;
    logic signed [XLEN-1:0] result_p1;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   cand;
    logic             accept;
    logic             complete;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur);
        if (cur == IDX_W'(N_REQ - 1))
            return '0;
        return cur + 1'b1;
    endfunction

    // Scan from the highest offset down so the lowest offset past rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N_REQ))
                cand = cand - (IDX_W + 1)'(N_REQ);
            if (bus.req_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign accept   = (state_q == IDLE) && win_found;
    assign complete = (state_q == RESP) && bus.rsp_ready[owner_p0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            op_count <= '0;
        end else begin
            state_q <= state_d;
            if (complete) begin
                rr_ptr_q <= next_ptr(owner_p0);
                op_count <= op_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready[owner_p0]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant is qualified by rst_n so nothing is offered while reset is held.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found && rst_n)
                    bus.req_ready[win_idx] = 1'b1;
            end
            EXEC: busy = 1'b1;
            RESP: begin
                busy                    = 1'b1;
                bus.rsp_valid[owner_p0] = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Stage p0: operands captured on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_p0 <= '0;
            src_a_p0 <= '0;
            src_b_p0 <= '0;
            op_p0    <= ALU_ADD;
        end else if (accept) begin
            owner_p0 <= win_idx;
            src_a_p0 <= bus.req_src_a[int'(win_idx)*XLEN +: XLEN];
            src_b_p0 <= bus.req_src_b[int'(win_idx)*XLEN +: XLEN];
            op_p0    <= bus.req_op[int'(win_idx)*OP_W +: OP_W];
        end
    end

    // Stage p1: ALU output captured at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            result_p1 <= '0;
        else if (state_q == EXEC)
            result_p1 <= alu_result;
    end

    assign alu_src_a      = src_a_p0;
    assign alu_src_b      = src_b_p0;
    assign alu_op         = op_p0;
    assign bus.rsp_result = result_p1;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: bench-side ALU model plus hand-computed
// expectations for accept timing, round-robin order, backpressure, reset and counter wrap.
module tb_alu_share_arbiter;
    localparam int N_REQ = 2;
    localparam int XLEN  = 32;
    localparam int OP_W  = 4;
    localparam int CNT_W = 16;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_LT   = 4'd3;
    localparam logic [3:0] OP_LTU  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_BPS2 = 4'd10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [OP_W-1:0]  alu_opc;
    logic [XLEN-1:0]  alu_res;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_res [2];

    alu_share_arbiter_if #(.N_REQ(N_REQ), .XLEN(XLEN), .OP_W(OP_W)) bus ();

    alu_share_arbiter #(
        .N_REQ(N_REQ), .XLEN(XLEN), .OP_W(OP_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_src_a  (alu_a),
        .alu_src_b  (alu_b),
        .alu_op     (alu_opc),
        .alu_result (alu_res),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_LT:   return {31'd0, $signed(a) < $signed(b)};
            OP_LTU:  return {31'd0, a < b};
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $signed(a) >>> b[4:0];
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_BPS2: return b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res = alu_model(alu_a, alu_b, alu_opc);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        bus.req_src_a[i*XLEN +: XLEN] = a;
        bus.req_src_b[i*XLEN +: XLEN] = b;
        bus.req_op[i*OP_W +: OP_W]    = op;
    endtask

    initial begin
        exp_res[0] = 32'h0000_00A5;
        exp_res[1] = 32'h0000_162E;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_src_a = '0;
        bus.req_src_b = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 2'b11;
        #2;
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_op_count", 64'(op_count), 64'h0);
        chk("rst_alu_op", 64'(alu_opc), 64'(OP_ADD));
        chk("rst_alu_a", 64'(alu_a), 64'h0);
        chk("rst_rsp_result", 64'(bus.rsp_result), 64'h0);
        tick();
        rst_n = 1'b1;

        // Single request
        tick();
        set_req(0, 32'd10, 32'd15, OP_ADD);
        bus.req_valid = 2'b01;
        #1;
        chk("t1_req_ready", 64'(bus.req_ready), 64'h1);
        chk("t1_idle_busy", 64'(busy), 64'h0);
        tick();
        bus.req_valid = 2'b00;
        chk("t1_exec_busy", 64'(busy), 64'h1);
        chk("t1_exec_ready", 64'(bus.req_ready), 64'h0);
        chk("t1_alu_a", 64'(alu_a), 64'd10);
        chk("t1_alu_b", 64'(alu_b), 64'd15);
        chk("t1_alu_op", 64'(alu_opc), 64'(OP_ADD));
        chk("t1_exec_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        tick();
        chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("t1_rsp_result", 64'(bus.rsp_result), 64'd25);
        tick();
        chk("t1_op_count", 64'(op_count), 64'd1);
        chk("t1_done_busy", 64'(busy), 64'h0);
        chk("t1_done_rsp_valid", 64'(bus.rsp_valid), 64'h0);

        rst_n = 1'b0;
        #1;
        chk("pulse_op_count", 64'(op_count), 64'h0);
        rst_n = 1'b1;

        // Contention from rr_ptr=0
        tick();
        set_req(0, 32'd20, 32'd5, OP_SUB);
        set_req(1, 32'hFFFF_FFE0, 32'd2, OP_SRA);
        bus.req_valid = 2'b11;
        #1;
        chk("t2_grant0", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 2'b10;
        #1;
        chk("t2_exec_ready", 64'(bus.req_ready), 64'h0);
        tick();
        chk("t2_rsp0_valid", 64'(bus.rsp_valid), 64'h1);
        chk("t2_rsp0_result", 64'(bus.rsp_result), 64'd15);
        tick();
        chk("t2_grant1", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 2'b00;
        tick();
        chk("t2_rsp1_valid", 64'(bus.rsp_valid), 64'h2);
        chk("t2_rsp1_result", 64'(bus.rsp_result), 64'hFFFF_FFF8);
        tick();
        chk("t2_busy", 64'(busy), 64'h0);
        chk("t2_op_count", 64'(op_count), 64'd2);
        bus.req_valid = 2'b11;
        #1;
        chk("t2_rr_ptr0", 64'(bus.req_ready), 64'h1);
        bus.req_valid = 2'b00;

        // Backpressure on requester 1; non-owner rsp_ready is ignored
        set_req(1, 32'd1, 32'hFFFF_FFFF, OP_LTU);
        bus.rsp_ready = 2'b01;
        bus.req_valid = 2'b10;
        #1;
        chk("t3_grant1", 64'(bus.req_ready), 64'h2);
        tick();
        set_req(0, 32'h0000_00AA, 32'h0000_000F, OP_XOR);
        set_req(1, 32'd1234, 32'd5678, OP_BPS2);
        bus.req_valid = 2'b01;
        #1;
        chk("t3_exec_ready", 64'(bus.req_ready), 64'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_hold_valid", 64'(bus.rsp_valid), 64'h2);
            chk("t3_hold_result", 64'(bus.rsp_result), 64'h1);
            chk("t3_hold_busy", 64'(busy), 64'h1);
            chk("t3_hold_no_grant", 64'(bus.req_ready), 64'h0);
        end
        tick();
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        chk("t3_last_valid", 64'(bus.rsp_valid), 64'h2);
        tick();
        chk("t3_op_count", 64'(op_count), 64'd3);

        // Fairness: six back-to-back ops with both requesters valid
        for (int k = 0; k < 6; k++) begin
            chk("t4_grant", 64'(bus.req_ready), 64'(2'b01 << (k % 2)));
            tick();
            chk("t4_exec_busy", 64'(busy), 64'h1);
            tick();
            chk("t4_rsp_valid", 64'(bus.rsp_valid), 64'(2'b01 << (k % 2)));
            chk("t4_rsp_result", 64'(bus.rsp_result), 64'(exp_res[k % 2]));
            tick();
        end
        chk("t4_op_count", 64'(op_count), 64'd9);
        chk("t4_next_grant", 64'(bus.req_ready), 64'h1);
        bus.req_valid = 2'b00;

        // Reset while in EXEC
        set_req(1, 32'd7, 32'd8, OP_ADD);
        bus.req_valid = 2'b10;
        #1;
        chk("t5_grant1", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 2'b00;
        chk("t5_exec_busy", 64'(busy), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'h0);
        chk("t5_rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("t5_rst_op_count", 64'(op_count), 64'h0);
        chk("t5_rst_alu_a", 64'(alu_a), 64'h0);
        chk("t5_rst_rsp_result", 64'(bus.rsp_result), 64'h0);
        bus.req_valid = 2'b01;
        #1;
        chk("t5_rst_req_ready", 64'(bus.req_ready), 64'h0);
        bus.req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_post_rsp_valid", 64'(bus.rsp_valid), 64'h0);
            chk("t5_post_busy", 64'(busy), 64'h0);
        end
        chk("t5_post_op_count", 64'(op_count), 64'h0);

        // Counter wrap from preloaded all-ones
        force dut.op_count = 16'hFFFF;
        tick();
        release dut.op_count;
        #1;
        chk("t6_preload", 64'(op_count), 64'hFFFF);
        set_req(0, 32'd3, 32'd4, OP_ADD);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        tick();
        chk("t6_rsp_result", 64'(bus.rsp_result), 64'd7);
        chk("t6_pre_wrap", 64'(op_count), 64'hFFFF);
        tick();
        chk("t6_wrap", 64'(op_count), 64'h0);
        chk("t6_busy", 64'(busy), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational `alu` instance between N_REQ requesters, for example the execute stage and a branch/compare unit.
- Arbitrates requests round-robin and registers the winner's operands.
- Drives the ALU from those registers and captures the result.
- Returns the result to the winner over a valid/ready response channel.
- Sits between requesting pipeline units and the single ALU in the execution block.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- XLEN, 32, operand/result width.
- OP_W, 4, width of the aluOpType encoding from riscv_definitions.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accept; at most one bit high per cycle.
- req_src_a  in  N_REQ*XLEN  flattened SrcA; requester i occupies bits [i*XLEN +: XLEN].
- req_src_b  in  N_REQ*XLEN  flattened SrcB; same packing as req_src_a.
- req_op  in  N_REQ*OP_W  flattened Operation codes (aluOpType).
- alu_src_a  out  XLEN  to ALU SrcA.
- alu_src_b  out  XLEN  to ALU SrcB.
- alu_op  out  OP_W  to ALU Operation.
- alu_result  in  XLEN  from ALU ALUResult; combinational from alu_src_a/alu_src_b/alu_op.
- rsp_valid  out  N_REQ  per-requester result valid; one-hot or zero.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_result  out  XLEN  result; shared bus, qualified by rsp_valid.
- busy  out  1  high whenever state != IDLE.
- op_count  out  CNT_W  completed operations; wraps.

Behaviour:
- Reset (rst_n low, asynchronous) clears all registers:
  - state=IDLE, rr_ptr=0, owner=0.
  - Operand registers and result register = 0.
  - alu_op = ALU_ADD encoding; op_count=0.
  - All outputs low/zero, including req_ready, rsp_valid and busy.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Winner = first set bit of req_valid, scanning from rr_ptr upward modulo N_REQ.
  - req_ready[winner] is asserted combinationally in the same cycle; all other req_ready bits stay 0.
  - On that edge, latch the winner's src_a/src_b/op into the operand registers and owner=winner, then go to EXEC.
  - If req_valid==0, stay in IDLE.
  - req_ready is 0 in every other state.
- EXEC:
  - alu_src_a/alu_src_b/alu_op are driven from the operand registers; they hold their values outside EXEC as well.
  - At the end of the cycle, result register <= alu_result; go to RESP.
- RESP:
  - rsp_valid[owner]=1 and rsp_result = result register.
  - Hold both stable while rsp_ready[owner]==0.
  - On the rsp_ready[owner]==1 edge: go to IDLE, rr_ptr <= (owner+1) mod N_REQ, op_count <= op_count+1 (wraps from all-ones to 0).
  - rsp_ready bits of non-owners are ignored.
- Latency: accept at cycle T, rsp_valid at T+2. With rsp_ready held high, the next accept is at T+3, so peak throughput is 1 op per 3 cycles.
- Fairness: after requester i is served, i has the lowest priority in the next arbitration. Under continuous contention requesters are served strictly in rotation.
- Request rules:
  - Operands are sampled only on the accept edge; later changes have no effect.
  - A requester may deassert req_valid without being accepted; no state is retained.
- Simultaneous events: a new request arriving while in EXEC/RESP waits. The requester must keep req_valid asserted with stable payload until accepted.
- Reset mid-operation: an in-flight operation is discarded. No rsp_valid is produced for it after reset; rr_ptr returns to 0.
- No combinational path from rsp_ready to req_ready.
  - req_ready depends only on state, rr_ptr and req_valid.

Test Plan:
1. Single request: req0 ADD 10,15 -> req_ready[0] in cycle 0, rsp_valid[0] at cycle 2, rsp_result=25, op_count=1.
2. Contention, rr_ptr=0: req0 SUB 20,5 and req1 SRA -32,2 held valid.
   - req0 served first with 15.
   - req1 accepted at the next IDLE with 0xFFFFFFF8.
   - rr_ptr ends at 0.
3. Backpressure: req1 LTU 1,0xFFFFFFFF with rsp_ready[1] low for 5 cycles.
   - rsp_valid[1] and rsp_result=1 stay stable, busy=1.
   - req0 is not accepted meanwhile.
   - Completion occurs on the cycle rsp_ready[1] rises.
4. Fairness: both requesters valid for 6 consecutive ops -> grant order 0,1,0,1,0,1; each result checked (XOR 0xAA,0x0F=0xA5; BPS2 1234,5678=5678).
5. Reset in EXEC: assert rst_n low mid-op -> all outputs zero immediately; after release no rsp_valid appears until a new request is made; op_count=0.
6. Counter wrap: force 2^CNT_W completions, or preload in simulation -> op_count rolls from 0xFFFF to 0x0000.
